// File: rtl/dff_shift_reg.sv
// Load / shift / rotate register with a step-counting IDLE/RUN sequencer.
// Optional PAR output is enabled by defining DFF_SHIFT_REG_PARITY_EN.
module dff_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [1:0]             MODE,
  input  logic [$clog2(WIDTH):0] AMT,
  input  logic [WIDTH-1:0]       D,
  input  logic                   SIN,
  output logic [WIDTH-1:0]       Q1,
  output logic [WIDTH-1:0]       Q2,
  output logic                   BUSY,
  output logic                   DONE
`ifdef DFF_SHIFT_REG_PARITY_EN
  ,
  output logic                   PAR
`endif
);

  localparam int AW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic             done_q, done_d;

  logic [AW-1:0]    amt_eff;
  logic [1:0]       sel_mode;
  logic [WIDTH-1:0] step_val;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      q1_q    <= RESET_VAL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q1_q    <= q1_d;
      done_q  <= done_d;
    end
  end

  // Once running, the mode captured at START drives every step.
  always_comb begin
    amt_eff  = (AMT > AW'(WIDTH)) ? AW'(WIDTH) : AMT;
    sel_mode = (state_q == RUN) ? mode_q : MODE;
    step_val = q1_q;
    case (sel_mode)
      2'b01:   step_val = {q1_q[WIDTH-2:0], SIN};
      2'b10:   step_val = {SIN, q1_q[WIDTH-1:1]};
      2'b11:   step_val = {q1_q[0], q1_q[WIDTH-1:1]};
      default: step_val = q1_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q1_d    = q1_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (MODE == 2'b00) begin
            q1_d   = D;
            done_d = 1'b1;
          end else if (amt_eff == '0) begin
            done_d = 1'b1;
          end else begin
            q1_d = step_val;
            if (amt_eff == AW'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              cnt_d   = amt_eff - AW'(1);
              mode_d  = MODE;
            end
          end
        end
      end
      RUN: begin
        q1_d  = step_val;
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Q1   = q1_q;
    Q2   = ~q1_q;
    BUSY = (state_q == RUN);
    DONE = done_q;
  end

`ifdef DFF_SHIFT_REG_PARITY_EN
  assign PAR = ^q1_q;
`endif

endmodule

// File: tb/tb_dff_shift_reg.sv
// Directed bench for dff_shift_reg, WIDTH=8, RESET_VAL=0.
// Defining DFF_SHIFT_REG_PARITY_EN also exercises PAR.
module tb_dff_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [3:0] amt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q1;
  logic [7:0] q2;
  logic       busy;
  logic       done;
`ifdef DFF_SHIFT_REG_PARITY_EN
  logic       par;
`endif

  int n_pass;
  int n_total;

  dff_shift_reg #(
    .WIDTH(8),
    .RESET_VAL(8'h00)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .START(start),
    .MODE(mode),
    .AMT(amt),
    .D(d),
    .SIN(sin),
    .Q1(q1),
    .Q2(q2),
    .BUSY(busy),
    .DONE(done)
`ifdef DFF_SHIFT_REG_PARITY_EN
    ,
    .PAR(par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    start = 1'b1;
    mode  = 2'b00;
    d     = v;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    amt   = 4'd0;
    d     = 8'h00;
    sin   = 1'b0;
    #2;
    n_total++;
    if ({q1, q2, busy, done} !== {8'h00, 8'hFF, 1'b0, 1'b0})
      $display("FAIL reset_init q1=%h q2=%h busy=%b done=%b exp 00 ff 0 0",
               q1, q2, busy, done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    load(8'h3C);
    n_total++;
    if ({q1, done} !== {8'h3C, 1'b1})
      $display("FAIL first_start q1=%h done=%b exp 3c 1", q1, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_load();
    int busy_seen;
    busy_seen = 0;
    load(8'hA5);
    if (busy) busy_seen++;
    n_total++;
    if ({q1, q2, done} !== {8'hA5, 8'h5A, 1'b1})
      $display("FAIL load q1=%h q2=%h done=%b exp a5 5a 1", q1, q2, done);
    else n_pass++;
    tick();
    if (busy) busy_seen++;
    n_total++;
    if ({done, busy_seen} !== {1'b0, 32'd0})
      $display("FAIL load_pulse done=%b busy_seen=%0d exp 0 0",
               done, busy_seen);
    else n_pass++;
  endtask

  task automatic test_shift_left();
    logic [7:0] seq [3];
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    load(8'h81);
    tick();
    start = 1'b1;
    mode  = 2'b01;
    amt   = 4'd3;
    sin   = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      start = 1'b0;
      seq[e] = q1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    n_total++;
    if ({seq[0], seq[1], seq[2]} !== {8'h03, 8'h07, 8'h0F})
      $display("FAIL shl_seq got %h %h %h exp 03 07 0f",
               seq[0], seq[1], seq[2]);
    else n_pass++;
    n_total++;
    if ({busy_cnt, done_cnt, done} !== {32'd2, 32'd1, 1'b1})
      $display("FAIL shl_ctl busy=%0d done=%0d last_done=%b exp 2 1 1",
               busy_cnt, done_cnt, done);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0)
      $display("FAIL shl_done_clear done=%b exp 0", done);
    else n_pass++;
  endtask

  task automatic test_rotate();
    int done_cnt;
    logic [7:0] q_at4;
    done_cnt = 0;
    q_at4 = 8'h00;
    load(8'hA5);
    tick();
    start = 1'b1;
    mode  = 2'b11;
    amt   = 4'd4;
    sin   = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) begin
        mode = 2'b00;
        d    = 8'hFF;
      end
      if (e == 3) start = 1'b0;
      if (e == 4) q_at4 = q1;
      if (done) done_cnt++;
    end
    n_total++;
    if (q_at4 !== 8'h5A)
      $display("FAIL rotr_val got %h exp 5a", q_at4);
    else n_pass++;
    n_total++;
    if ({q1, done_cnt} !== {8'h5A, 32'd1})
      $display("FAIL rotr_ignore q1=%h dones=%0d exp 5a 1", q1, done_cnt);
    else n_pass++;
  endtask

  task automatic test_boundary();
    int done_edge;
    logic [7:0] q_at7;
    done_edge = -1;
    q_at7 = 8'h00;
    start = 1'b1;
    mode  = 2'b01;
    amt   = 4'd0;
    sin   = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({q1, done, busy} !== {8'h5A, 1'b1, 1'b0})
      $display("FAIL amt0 q1=%h done=%b busy=%b exp 5a 1 0",
               q1, done, busy);
    else n_pass++;
    load(8'hFF);
    tick();
    start = 1'b1;
    mode  = 2'b10;
    amt   = 4'd12;
    sin   = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      start = 1'b0;
      if (e == 7) q_at7 = q1;
      if (done && done_edge < 0) done_edge = e;
    end
    n_total++;
    if (done_edge != 8)
      $display("FAIL clip_done_edge got %0d exp 8", done_edge);
    else n_pass++;
    n_total++;
    if ({q_at7, q1} !== {8'h01, 8'h00})
      $display("FAIL clip_val q7=%h q=%h exp 01 00", q_at7, q1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    load(8'h3C);
    start = 1'b1;
    mode  = 2'b01;
    amt   = 4'd1;
    sin   = 1'b0;
    tick();
    n_total++;
    if ({q1, done, busy} !== {8'h78, 1'b1, 1'b0})
      $display("FAIL b2b_shl q1=%h done=%b busy=%b exp 78 1 0",
               q1, done, busy);
    else n_pass++;
    mode = 2'b10;
    sin  = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({q1, done} !== {8'hBC, 1'b1})
      $display("FAIL b2b_shr q1=%h done=%b exp bc 1", q1, done);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0)
      $display("FAIL b2b_clear done=%b exp 0", done);
    else n_pass++;
  endtask

  task automatic test_hold();
    load(8'h96);
    mode = 2'b00;
    for (int e = 0; e < 4; e++) begin
      d = 8'(e * 37 + 5);
      tick();
    end
    n_total++;
    if ({q1, done} !== {8'h96, 1'b0})
      $display("FAIL hold q1=%h done=%b exp 96 0", q1, done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int done_cnt;
    done_cnt = 0;
    load(8'h01);
    start = 1'b1;
    mode  = 2'b01;
    amt   = 4'd8;
    sin   = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      start = 1'b0;
    end
    n_total++;
    if ({q1, busy} !== {8'h0F, 1'b1})
      $display("FAIL run_pre q1=%h busy=%b exp 0f 1", q1, busy);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({q1, q2, busy, done} !== {8'h00, 8'hFF, 1'b0, 1'b0})
      $display("FAIL async_rst q1=%h q2=%h busy=%b done=%b exp 00 ff 0 0",
               q1, q2, busy, done);
    else n_pass++;
    for (int e = 0; e < 2; e++) begin
      tick();
      if (done) done_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (done) done_cnt++;
    end
    n_total++;
    if ({q1, busy, done_cnt} !== {8'h00, 1'b0, 32'd0})
      $display("FAIL abort q1=%h busy=%b dones=%0d exp 00 0 0",
               q1, busy, done_cnt);
    else n_pass++;
  endtask

`ifdef DFF_SHIFT_REG_PARITY_EN
  task automatic test_parity();
    load(8'h07);
    n_total++;
    if (par !== 1'b1) $display("FAIL par_07 par=%b exp 1", par);
    else n_pass++;
    load(8'h0F);
    n_total++;
    if (par !== 1'b0) $display("FAIL par_0f par=%b exp 0", par);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_load();
    test_shift_left();
    test_rotate();
    test_boundary();
    test_back_to_back();
    test_hold();
    test_reset_mid_run();
`ifdef DFF_SHIFT_REG_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
